// File: rtl/free_list.sv
// Free list of physical register numbers for a two-wide rename stage.
// Define FREELIST_ERR_EN to add the sticky fl_err protocol-violation flag.
module free_list (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       recover,
  input  logic       alloc_req1,
  input  logic       alloc_req2,
  output logic [5:0] alloc_prn1,
  output logic [5:0] alloc_prn2,
  output logic       fl_stall,
  input  logic       rel_en1,
  input  logic       rel_en2,
  input  logic [5:0] rel_prn1,
  input  logic [5:0] rel_prn2,
  input  logic       cmt_alloc1,
  input  logic       cmt_alloc2,
`ifdef FREELIST_ERR_EN
  output logic       fl_err,
`endif
  output logic [5:0] free_cnt
);

  logic [5:0] entries [32];
  logic [5:0] head;
  logic [5:0] cmt_head;
  logic [5:0] tail;

  logic [1:0] req_cnt;
  logic [1:0] rel_cnt;
  logic [1:0] cmt_cnt;
  logic [5:0] head_p1;
  logic [5:0] tail_p1;
  logic [5:0] cmt_head_nxt;
  logic       alloc_ok;

  assign req_cnt      = {1'b0, alloc_req1} + {1'b0, alloc_req2};
  assign rel_cnt      = {1'b0, rel_en1} + {1'b0, rel_en2};
  assign cmt_cnt      = {1'b0, cmt_alloc1} + {1'b0, cmt_alloc2};
  assign head_p1      = head + 6'd1;
  assign tail_p1      = tail + 6'd1;
  assign cmt_head_nxt = cmt_head + {4'b0, cmt_cnt};

  assign free_cnt   = tail - head;
  assign fl_stall   = free_cnt < {4'b0, req_cnt};
  assign alloc_ok   = !stall && !fl_stall && !recover;

  // Same-cycle releases are not forwarded; they appear here next cycle.
  assign alloc_prn1 = entries[head[4:0]];
  assign alloc_prn2 = alloc_req1 ? entries[head_p1[4:0]] : entries[head[4:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        entries[i] <= 6'(32 + i);
      end
      head     <= 6'd0;
      cmt_head <= 6'd0;
      tail     <= 6'd32;
    end else begin
      if (rel_en1) begin
        entries[tail[4:0]] <= rel_prn1;
      end
      if (rel_en2) begin
        if (rel_en1) begin
          entries[tail_p1[4:0]] <= rel_prn2;
        end else begin
          entries[tail[4:0]] <= rel_prn2;
        end
      end
      tail     <= tail + {4'b0, rel_cnt};
      cmt_head <= cmt_head_nxt;

      // Recovery rolls speculation back to the committed point of this edge.
      if (recover) begin
        head <= cmt_head_nxt;
      end else if (alloc_ok) begin
        head <= head + {4'b0, req_cnt};
      end
    end
  end

`ifdef FREELIST_ERR_EN
  logic [6:0] free_after_rel;
  logic [5:0] outstanding;
  logic       violation;

  assign free_after_rel = {1'b0, free_cnt} + {5'b0, rel_cnt};
  assign outstanding    = head - cmt_head;
  assign violation      = (free_after_rel > 7'd32) || ({4'b0, cmt_cnt} > outstanding);

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_err <= 1'b0;
    end else if (violation) begin
      fl_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list: allocation, stalls, releases,
// recovery, pointer wrap, reset priority and (when enabled) the error flag.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       recover;
  logic       alloc_req1;
  logic       alloc_req2;
  logic [5:0] alloc_prn1;
  logic [5:0] alloc_prn2;
  logic       fl_stall;
  logic       rel_en1;
  logic       rel_en2;
  logic [5:0] rel_prn1;
  logic [5:0] rel_prn2;
  logic       cmt_alloc1;
  logic       cmt_alloc2;
  logic [5:0] free_cnt;
`ifdef FREELIST_ERR_EN
  logic       fl_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  free_list dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .recover    (recover),
    .alloc_req1 (alloc_req1),
    .alloc_req2 (alloc_req2),
    .alloc_prn1 (alloc_prn1),
    .alloc_prn2 (alloc_prn2),
    .fl_stall   (fl_stall),
    .rel_en1    (rel_en1),
    .rel_en2    (rel_en2),
    .rel_prn1   (rel_prn1),
    .rel_prn2   (rel_prn2),
    .cmt_alloc1 (cmt_alloc1),
    .cmt_alloc2 (cmt_alloc2),
`ifdef FREELIST_ERR_EN
    .fl_err     (fl_err),
`endif
    .free_cnt   (free_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs settle 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; recover = 0; alloc_req1 = 0; alloc_req2 = 0;
    rel_en1 = 0; rel_en2 = 0; rel_prn1 = 0; rel_prn2 = 0;
    cmt_alloc1 = 0; cmt_alloc2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    tick();
    rst = 0;
    #1;

    // Reset state
    chk("rst_free_cnt", 8'(free_cnt), 8'd32);
    chk("rst_prn1", 8'(alloc_prn1), 8'd32);
    chk("rst_prn2_noreq1", 8'(alloc_prn2), 8'd32);
    chk("rst_fl_stall", 8'(fl_stall), 8'd0);
    alloc_req1 = 1; #1;
    chk("rst_prn2_req1", 8'(alloc_prn2), 8'd33);

    // Dual allocation
    alloc_req2 = 1; #1;
    chk("dual_prn1", 8'(alloc_prn1), 8'd32);
    chk("dual_prn2", 8'(alloc_prn2), 8'd33);
    tick();
    idle(); #1;
    chk("dual_free_cnt", 8'(free_cnt), 8'd30);
    chk("dual_next_prn1", 8'(alloc_prn1), 8'd34);

    // Drain to one free register, then insufficient-free stall
    do_reset();
    for (int i = 0; i < 15; i++) begin
      alloc_req1 = 1; alloc_req2 = 1;
      tick();
    end
    alloc_req2 = 0;
    tick();
    idle(); #1;
    chk("drain_free_cnt", 8'(free_cnt), 8'd1);
    chk("drain_prn1", 8'(alloc_prn1), 8'd63);
    alloc_req1 = 1; alloc_req2 = 1; #1;
    chk("short_fl_stall", 8'(fl_stall), 8'd1);
    tick();
    chk("short_head_held", 8'(free_cnt), 8'd1);
    alloc_req1 = 0; alloc_req2 = 1; #1;
    chk("req2_only_prn2", 8'(alloc_prn2), 8'd63);
    chk("req2_only_no_stall", 8'(fl_stall), 8'd0);
    tick();
    idle(); #1;
    chk("empty_free_cnt", 8'(free_cnt), 8'd0);

    // Release while empty: no same-cycle bypass
    rel_en1 = 1; rel_prn1 = 6'd5; alloc_req1 = 1; #1;
    chk("empty_req_fl_stall", 8'(fl_stall), 8'd1);
    tick();
    idle(); #1;
    chk("rel_next_prn1", 8'(alloc_prn1), 8'd5);
    chk("rel_next_free_cnt", 8'(free_cnt), 8'd1);
    rel_en2 = 1; rel_prn2 = 6'd7;
    tick();
    idle(); alloc_req1 = 1; #1;
    chk("rel2_only_free_cnt", 8'(free_cnt), 8'd2);
    chk("rel2_only_prn2", 8'(alloc_prn2), 8'd7);
    rel_en1 = 1; rel_prn1 = 6'd9; rel_en2 = 1; rel_prn2 = 6'd10; alloc_req2 = 1;
    tick();
    idle(); alloc_req1 = 1; alloc_req2 = 1; #1;
    chk("rel_dual_free_cnt", 8'(free_cnt), 8'd2);
    chk("rel_dual_prn1", 8'(alloc_prn1), 8'd9);
    chk("rel_dual_prn2", 8'(alloc_prn2), 8'd10);

    // Recovery to commit point
    do_reset();
    alloc_req1 = 1; alloc_req2 = 1;
    tick(); tick();
    idle(); #1;
    chk("pre_recover_free_cnt", 8'(free_cnt), 8'd28);
    cmt_alloc1 = 1; recover = 1; alloc_req1 = 1; alloc_req2 = 1;
    tick();
    idle(); #1;
    chk("recover_free_cnt", 8'(free_cnt), 8'd31);
    chk("recover_prn1", 8'(alloc_prn1), 8'd33);

    // Stall freezes allocation
    do_reset();
    stall = 1; alloc_req1 = 1; alloc_req2 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_free_cnt", 8'(free_cnt), 8'd32);
      chk("stall_prn1", 8'(alloc_prn1), 8'd32);
    end

    // Full lap: pointers and buffer index wrap
    stall = 0;
    for (int i = 0; i < 16; i++) tick();
    idle(); #1;
    chk("lap_empty", 8'(free_cnt), 8'd0);
    for (int i = 0; i < 16; i++) begin
      rel_en1 = 1; rel_prn1 = 6'(2 * i);
      rel_en2 = 1; rel_prn2 = 6'(2 * i + 1);
      tick();
    end
    idle(); alloc_req1 = 1; alloc_req2 = 1; #1;
    chk("lap_free_cnt", 8'(free_cnt), 8'd32);
    chk("lap_prn1", 8'(alloc_prn1), 8'd0);
    chk("lap_prn2", 8'(alloc_prn2), 8'd1);
    tick();
    idle(); #1;
    chk("lap_alloc_free_cnt", 8'(free_cnt), 8'd30);
    chk("lap_alloc_prn1", 8'(alloc_prn1), 8'd2);

    // Reset wins over everything in the same cycle
    rst = 1; alloc_req1 = 1; alloc_req2 = 1; recover = 1; cmt_alloc1 = 1;
    rel_en1 = 1; rel_prn1 = 6'd3;
    tick();
    rst = 0; idle(); #1;
    chk("rst_prio_free_cnt", 8'(free_cnt), 8'd32);
    chk("rst_prio_prn1", 8'(alloc_prn1), 8'd32);

`ifdef FREELIST_ERR_EN
    chk("err_clear", 8'(fl_err), 8'd0);
    rel_en1 = 1; rel_prn1 = 6'd1;
    tick();
    idle(); #1;
    chk("err_set", 8'(fl_err), 8'd1);
    tick(); tick();
    chk("err_sticky", 8'(fl_err), 8'd1);
    do_reset();
    chk("err_rst", 8'(fl_err), 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have ports clk (input, 1, sole clock, rising edge) and rst (input, 1, synchronous, active-high reset); reset is synchronous and active-high.
REQ-002 SHALL have stall (input, 1): rename stage frozen, no allocation this cycle.
REQ-003 SHALL have recover (input, 1): mispredict/exception flush, discard speculative allocations.
REQ-004 SHALL have alloc_req1, alloc_req2 (input, 1 each): instruction 1 / 2 in rename needs a destination physical register.
REQ-005 SHALL have alloc_prn1, alloc_prn2 (output, 6 each): physical register numbers offered to instruction 1 / 2.
REQ-006 SHALL have fl_stall (output, 1): insufficient free registers for this cycle's requests.
REQ-007 SHALL have rel_en1, rel_en2 (input, 1 each) and rel_prn1, rel_prn2 (input, 6 each): commit returns old destination physical registers.
REQ-008 SHALL have cmt_alloc1, cmt_alloc2 (input, 1 each): committing instruction 1 / 2 had allocated a register.
REQ-009 SHALL have free_cnt (output, 6): number of speculatively free registers, 0..32.

Function
REQ-010 SHALL hold a 32-entry circular buffer of 6-bit physical numbers; 64 physical registers, 32 always architecturally mapped.
REQ-011 SHALL keep 6-bit pointers (5-bit index + wrap bit): head (speculative read), cmt_head (committed read), tail (write); free_cnt = tail - head mod 64.
REQ-012 SHALL drive alloc_prn1 = entry[head]; alloc_prn2 = entry[head+1] if alloc_req1 else entry[head]; combinational, zero latency.
REQ-013 SHALL assert fl_stall combinationally when free_cnt < alloc_req1 + alloc_req2.
REQ-014 SHALL advance head by alloc_req1 + alloc_req2 at the clock edge only when !stall && !fl_stall && !recover.
REQ-015 SHALL write rel_prn1 at tail, then rel_prn2 at next slot (or at tail if rel_en1=0), advancing tail by rel_en1 + rel_en2, regardless of stall, fl_stall or recover.
REQ-016 SHALL advance cmt_head by cmt_alloc1 + cmt_alloc2 every cycle, regardless of stall or recover.
REQ-017 SHALL, on recover, set head to the updated cmt_head value of the same edge (cmt_head + cmt_alloc1 + cmt_alloc2); free_cnt next cycle = new tail - new head.
REQ-018 SHALL not bypass same-cycle released numbers to alloc_prn1/2; releases become allocatable the following cycle.
REQ-019 SHALL wrap all pointers modulo 64, buffer index modulo 32.
REQ-020 SHALL treat release with free_cnt + releases > 32, or cmt_head passing head, as protocol violations (see REQ-025).

Reset
REQ-021 SHALL on rst at a rising edge set entry[i] = 32+i for i = 0..31, head = 0, cmt_head = 0, tail = 32 (wrap bit set), so free_cnt = 32.
REQ-022 SHALL give rst priority over recover, alloc, release and commit in the same cycle; mid-operation reset discards all state.
REQ-023 SHALL after reset output alloc_prn1 = 32, alloc_prn2 = 32 (no req1) or 33 (req1), fl_stall = 0.

Configuration
REQ-024 SHALL, with macro FREELIST_ERR_EN defined, add output fl_err (1): sticky, set the edge after any REQ-020 violation, cleared only by rst.
REQ-025 SHALL, without FREELIST_ERR_EN, omit fl_err; violations then corrupt pointers silently, no other behaviour change.

Verification
REQ-026 Reset, then req1=req2=1 one cycle -> alloc_prn1=32, alloc_prn2=33; next cycle free_cnt=30, alloc_prn1=34.
REQ-027 Allocate 31, then req1=req2=1 -> fl_stall=1, head unchanged; req2 only -> alloc_prn2=63, free_cnt=0 next.
REQ-028 free_cnt=0, rel_en1=1 rel_prn1=5 with req1=1 same cycle -> fl_stall=1 that cycle; next cycle alloc_prn1=5, free_cnt=1.
REQ-029 Allocate 4 (32..35), commit cmt_alloc1=1, recover same edge -> head=cmt_head=1, free_cnt=31, alloc_prn1=33.
REQ-030 stall=1 with req1=req2=1 for 3 cycles -> head, free_cnt unchanged, alloc_prn1 stays 32.
REQ-031 FREELIST_ERR_EN defined, release with free_cnt=32 -> fl_err=1 next cycle, remains 1 until rst.
